// File: rtl/comm_pkg.sv
// Shared types and constants for the comm_master command transmitter.
// Frame length depends on COMM_PARITY_EN (adds an even-parity bit before stop).
package comm_pkg;

   typedef enum logic [1:0] {IDLE, HIGH, LOW} cm_state_t;

   localparam int DEF_BAUD_DIV = 2604;
   localparam int DATA_BITS    = 8;

`ifdef COMM_PARITY_EN
   localparam int FRAME_BITS = DATA_BITS + 3;
`else
   localparam int FRAME_BITS = DATA_BITS + 2;
`endif

endpackage

// File: rtl/uart_tx.sv
// Single-byte UART transmitter: start, 8 data bits LSB first, optional even parity
// (COMM_PARITY_EN), stop. tx_done pulses one clock after the stop bit completes.
module uart_tx #(
   parameter int BAUD_DIV = comm_pkg::DEF_BAUD_DIV
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           trmt,
   input  logic [comm_pkg::DATA_BITS-1:0] tx_data,
   output logic                           TX,
   output logic                           tx_done
);

   localparam int NBITS = comm_pkg::FRAME_BITS;

   typedef enum logic {IDLE, TXING} tx_state_t;

   tx_state_t        state, nxt_state;
   logic [NBITS-1:0] shift_q, frame;
   logic [11:0]      baud_cnt;
   logic [3:0]       bit_cnt;
   logic             baud_tick, last_bit;
   logic             load, shift_en, finish;

   assign baud_tick = (baud_cnt == 12'd0);
   assign last_bit  = (bit_cnt == 4'(NBITS - 1));

`ifdef COMM_PARITY_EN
   assign frame = {1'b1, ^tx_data, tx_data, 1'b0};
`else
   assign frame = {1'b1, tx_data, 1'b0};
`endif

   // Line is the LSB of the shifter; ones shifted in keep it high once the stop bit is out
   assign TX = shift_q[0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= nxt_state;
   end

   always_comb begin
      nxt_state = state;
      case (state)
         IDLE:    if (trmt) nxt_state = TXING;
         TXING:   if (baud_tick && last_bit) nxt_state = IDLE;
         default: nxt_state = IDLE;
      endcase
   end

   always_comb begin
      load     = 1'b0;
      shift_en = 1'b0;
      finish   = 1'b0;
      case (state)
         IDLE:    load = trmt;
         TXING: begin
            shift_en = baud_tick && !last_bit;
            finish   = baud_tick && last_bit;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift_q  <= '1;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         tx_done  <= 1'b0;
      end else begin
         tx_done <= finish;
         if (load) begin
            shift_q  <= frame;
            baud_cnt <= 12'(BAUD_DIV - 1);
            bit_cnt  <= '0;
         end else if (shift_en) begin
            shift_q  <= {1'b1, shift_q[NBITS-1:1]};
            baud_cnt <= 12'(BAUD_DIV - 1);
            bit_cnt  <= bit_cnt + 4'd1;
         end else if (state == TXING && !baud_tick) begin
            baud_cnt <= baud_cnt - 12'd1;
         end
      end
   end

endmodule

// File: rtl/comm_master.sv
// Sends a 16-bit command as two UART frames, high byte first, and flags completion.
// Optional even parity per frame when COMM_PARITY_EN is defined.
module comm_master
   import comm_pkg::*;
#(
   parameter int BAUD_DIV = DEF_BAUD_DIV
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        snd_cmd,
   input  logic [15:0] cmd,
   output logic        TX,
   output logic        cmd_cmplt
);

   cm_state_t            state, nxt_state;
   logic [DATA_BITS-1:0] cmd_q, tx_data;
   logic                 trmt, tx_done, accept;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= nxt_state;
   end

   always_comb begin
      nxt_state = state;
      case (state)
         IDLE:    if (snd_cmd) nxt_state = HIGH;
         HIGH:    if (tx_done) nxt_state = LOW;
         LOW:     if (tx_done) nxt_state = IDLE;
         default: nxt_state = IDLE;
      endcase
   end

   // High byte goes straight from cmd on the accepting edge; only the low byte needs holding
   always_comb begin
      accept  = 1'b0;
      trmt    = 1'b0;
      tx_data = cmd_q;
      case (state)
         IDLE: begin
            accept  = snd_cmd;
            trmt    = snd_cmd;
            tx_data = cmd[15:8];
         end
         HIGH:    trmt = tx_done;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (accept) cmd_q <= cmd[7:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                          cmd_cmplt <= 1'b0;
      else if (accept)                  cmd_cmplt <= 1'b0;
      else if (state == LOW && tx_done) cmd_cmplt <= 1'b1;
   end

   uart_tx #(.BAUD_DIV(BAUD_DIV)) u_tx (
      .clk     (clk),
      .rst     (rst),
      .trmt    (trmt),
      .tx_data (tx_data),
      .TX      (TX),
      .tx_done (tx_done)
   );

endmodule

// File: tb/tb_comm_master.sv
// Bench for comm_master: a UART line receiver model decodes TX and a queue of
// expected bytes per accepted command is compared against it.
module tb_comm_master;

   localparam int B = 16;
`ifdef COMM_PARITY_EN
   localparam int FB = 11;
`else
   localparam int FB = 10;
`endif
   localparam int LAT   = 2 * FB * B + 2;
   localparam int PER   = LAT + 1;
   localparam int LIMIT = 3 * FB * B;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        snd_cmd = 1'b0;
   logic [15:0] cmd = '0;
   logic        TX, cmd_cmplt;

   int cyc = 0;
   int n_checks = 0;
   int n_errors = 0;
   int acc = 0;

   int          rise_q[$];
   int          width_q[$];
   int          start_q[$];
   logic [7:0]  rx_byte_q[$];
   logic [10:0] rx_frame_q[$];

   comm_master #(.BAUD_DIV(B)) dut (
      .clk       (clk),
      .rst       (rst),
      .snd_cmd   (snd_cmd),
      .cmd       (cmd),
      .TX        (TX),
      .cmd_cmplt (cmd_cmplt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // Line receiver: find the start edge, sample every bit at its middle, abort on reset
   initial begin : rx_model
      logic [10:0] f;
      int          st;
      bit          ab;
      int          mid;
      mid = B / 2;
      forever begin
         @(negedge clk);
         if (!rst && TX === 1'b0) begin
            st = cyc;
            f  = '1;
            ab = 1'b0;
            for (int n = 1; n <= mid + (FB - 1) * B; n++) begin
               @(negedge clk);
               if (rst) begin
                  ab = 1'b1;
                  break;
               end
               if (n >= mid && (n - mid) % B == 0) f[(n - mid) / B] = TX;
            end
            if (!ab) begin
               rx_byte_q.push_back(f[8:1]);
               rx_frame_q.push_back(f);
               start_q.push_back(st);
            end
         end
      end
   end

   initial begin : cmplt_mon
      logic prev;
      int   run;
      prev = 1'b0;
      run  = 0;
      forever begin
         @(negedge clk);
         if (cmd_cmplt === 1'b1) begin
            if (!prev) begin
               rise_q.push_back(cyc);
               run = 0;
            end
            run++;
         end else if (prev) begin
            width_q.push_back(run);
         end
         prev = (cmd_cmplt === 1'b1);
      end
   end

   task automatic flush();
      rise_q.delete();
      width_q.delete();
      start_q.delete();
      rx_byte_q.delete();
      rx_frame_q.delete();
   endtask

   task automatic send(input logic [15:0] c);
      tick();
      cmd     = c;
      snd_cmd = 1'b1;
      tick();
      acc     = cyc;
      snd_cmd = 1'b0;
      cmd     = 16'($urandom);
   endtask

   task automatic wait_rise(output int t);
      int n;
      n = 0;
      while (rise_q.size() == 0 && n < LIMIT) begin
         tick();
         n++;
      end
      if (rise_q.size() == 0) begin
         check("cmplt_seen", rise_q.size(), 1);
         t = -1;
      end else begin
         t = rise_q.pop_front();
      end
   endtask

   task automatic expect_cmd(input logic [15:0] c, input string tag);
      int          t, lat;
      logic [7:0]  eb;
      logic [10:0] f;
      wait_rise(t);
      if (t >= 0) begin
         lat = t - acc;
         check({tag, "_lat"}, (lat >= LAT - 1 && lat <= LAT + 1) ? LAT : lat, LAT);
      end
      check({tag, "_nbytes"}, rx_byte_q.size(), 2);
      for (int i = 0; i < 2 && rx_byte_q.size() > 0; i++) begin
         eb = (i == 0) ? c[15:8] : c[7:0];
         f  = rx_frame_q.pop_front();
         check({tag, "_byte"}, rx_byte_q.pop_front(), eb);
         check({tag, "_stop"}, f[FB-1], 1);
`ifdef COMM_PARITY_EN
         check({tag, "_par"}, f[9], $countones(eb) % 2);
`endif
      end
   endtask

   initial begin : watchdog
      #3000000;
      $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int          pat[10];
      int          r[3];
      int          n;
      logic [15:0] c;
      logic [10:0] f;

      pat = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

      repeat (3) tick();
      check("rst_tx", TX, 1);
      check("rst_cmplt", cmd_cmplt, 0);
      rst = 1'b0;
      tick();
      check("idle_tx", TX, 1);
      check("idle_cmplt", cmd_cmplt, 0);

      send(16'h5555);
      expect_cmd(16'h5555, "basic");
      repeat (3) tick();
      check("basic_tx_idle", TX, 1);
      check("basic_cmplt_hold", cmd_cmplt, 1);

      send(16'hA50F);
      n = 0;
      while (rx_frame_q.size() == 0 && n < LIMIT) begin
         tick();
         n++;
      end
      check("order_frame_seen", rx_frame_q.size(), 1);
      if (rx_frame_q.size() > 0) begin
         f = rx_frame_q[0];
         for (int i = 0; i < 9; i++) check("order_bit", f[i], pat[i]);
         check("order_bit_stop", f[FB-1], pat[9]);
      end
      expect_cmd(16'hA50F, "order");

      send(16'hFFFF);
      repeat (3 * B) tick();
      cmd     = 16'h0000;
      snd_cmd = 1'b1;
      repeat (5) tick();
      snd_cmd = 1'b0;
      repeat (FB * B) tick();
      snd_cmd = 1'b1;
      tick();
      snd_cmd = 1'b0;
      expect_cmd(16'hFFFF, "busy");
      repeat (LAT) tick();
      check("busy_extra_cmplt", rise_q.size(), 0);
      check("busy_extra_bytes", rx_byte_q.size(), 0);
      check("busy_tx_idle", TX, 1);
      check("busy_cmplt_hold", cmd_cmplt, 1);

      for (int k = 0; k < 8; k++) begin
         c = 16'($urandom);
         repeat ($urandom_range(0, 20)) tick();
         send(c);
         if ($urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(1, 2 * FB * B - 40)) tick();
            cmd     = 16'($urandom);
            snd_cmd = 1'b1;
            repeat ($urandom_range(1, 4)) tick();
            snd_cmd = 1'b0;
         end
         expect_cmd(c, "rand");
      end

      flush();
      tick();
      cmd     = 16'h002D;
      snd_cmd = 1'b1;
      tick();
      acc = cyc;
      width_q.delete();
      for (int k = 0; k < 3; k++) wait_rise(r[k]);
      snd_cmd = 1'b0;
      n = r[0] - acc;
      check("held_lat", (n >= LAT - 1 && n <= LAT + 1) ? LAT : n, LAT);
      for (int k = 1; k < 3; k++) begin
         n = r[k] - r[k-1];
         check("held_period", (n >= PER - 1 && n <= PER + 1) ? PER : n, PER);
      end
      check("held_nwidth", width_q.size(), 2);
      while (width_q.size() > 0) check("held_width", width_q.pop_front(), 1);
      check("held_nbytes", rx_byte_q.size(), 6);
      for (int k = 0; k < 6 && rx_byte_q.size() > 0; k++)
         check("held_byte", rx_byte_q.pop_front(), (k % 2 == 0) ? 8'h00 : 8'h2D);
      for (int k = 1; k < start_q.size(); k++) begin
         n = start_q[k] - start_q[k-1];
         check("held_gap", (n >= FB * B && n <= FB * B + 2) ? FB * B : n, FB * B);
      end
      repeat (2 * B) tick();
      check("held_tx_idle", TX, 1);
      check("held_cmplt_hold", cmd_cmplt, 1);

      flush();
      send(16'h00C3);
      repeat (5 * B + B / 2) tick();
      check("pre_rst_tx", TX, 0);
      rst = 1'b1;
      #1;
      check("mid_rst_tx", TX, 1);
      check("mid_rst_cmplt", cmd_cmplt, 0);
      repeat (3) tick();
      rst = 1'b0;
      tick();
      flush();
      send(16'h1234);
      expect_cmd(16'h1234, "after_rst");

      send(16'h0301);
      expect_cmd(16'h0301, "par");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
